pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Sequencer FSM that drives the program counter's load/increment controls (pc_load, pc_inc, pc_data) and fetches instructions from instruction memory at the current PC.
- Sits between the PC counter, instruction memory and the decode stage.
- Runs one instruction at a time: boot-load, request, wait for ack, issue downstream, then advance the PC (increment or branch).

Parameters:
- N, 32, PC/address/instruction width.
- RESET_VEC, 32, PC value loaded in BOOT.
- MAX_WAIT, 15, maximum REQ cycles without imem_ack before entering ERROR (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE/HALTED and begin fetching.
- halt  in  1  stop after the current instruction's PC update.
- pc_in  in  N  current PC value from the counter.
- pc_data  out  N  load value to the counter.
- pc_load  out  1  one-cycle load strobe to the counter.
- pc_inc  out  1  one-cycle increment strobe to the counter.
- imem_req  out  1  fetch request.
- imem_addr  out  N  fetch address (equals pc_in while imem_req=1).
- imem_ack  in  1  memory data valid this cycle.
- imem_rdata  in  N  fetched instruction.
- instr  out  N  registered instruction to decode.
- instr_valid  out  1  instr valid; held until instr_ready.
- instr_ready  in  1  decode accepts instr.
- br_valid  in  1  branch/jump request.
- br_target  in  N  branch target PC.
- busy  out  1  state not IDLE, HALTED or ERROR.
- err  out  1  sticky fetch-timeout flag.
- perf_fetch_cnt  out  32  see Optional Feature.
- perf_stall_cnt  out  32  see Optional Feature.

Behaviour:
- Reset: rst is sampled at the clk rising edge and has priority over everything, including mid-transfer.
  - State goes to IDLE.
  - All outputs are 0: instr=0, pc_data=0, err=0.
  - The pending-branch register and the wait counter are cleared.
- States: IDLE, BOOT, REQ, ISSUE, UPDATE, HALTED, ERROR.
- IDLE: start=1 -> BOOT; otherwise stay.
- BOOT (1 cycle): pc_load=1, pc_data=RESET_VEC -> REQ.
- REQ:
  - Outputs: imem_req=1, imem_addr=pc_in; the wait counter increments each cycle without ack.
  - imem_ack=1: instr<=imem_rdata, wait counter cleared -> ISSUE. An ack in the first REQ cycle costs zero wait cycles.
  - wait counter == MAX_WAIT with no ack: -> ERROR.
- ISSUE: instr_valid=1 and instr stable; instr_ready=1 -> UPDATE; otherwise hold.
- UPDATE (1 cycle):
  - Branch source priority: br_valid this cycle (br_target used directly), else the pending branch, else none.
  - Branch: pc_load=1, pc_data=target, pending cleared.
  - No branch: pc_inc=1.
  - Then halt=1 -> HALTED; else -> REQ.
- Counter timing: the counter updates on the edge ending UPDATE/BOOT, so pc_in is already correct in the following REQ cycle.
- Branch capture: br_valid in BOOT, REQ or ISSUE latches br_target into pending; the latest request overwrites. br_valid is ignored in IDLE, HALTED and ERROR.
- HALTED: start=1 and halt=0 -> REQ, with the PC kept (no reload).
- ERROR: err=1; all strobes and the request are 0; exits only via rst.
- Invariants:
  - pc_load & pc_inc never both 1.
  - imem_req=1 only in REQ.
  - instr_valid=1 only in ISSUE.
- Throughput: minimum 3 cycles per instruction (REQ with immediate ack, ISSUE with ready, UPDATE).

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- Defined:
  - perf_fetch_cnt increments on each ISSUE->UPDATE transition.
  - perf_stall_cnt increments each REQ cycle with imem_ack=0 and each ISSUE cycle with instr_ready=0.
  - Both are 32-bit, wrap at 2^32, and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter registers are built.

Test Plan:
- Boot: rst=1 2 cycles, then start=1 -> next cycle pc_load=1 with pc_data=32; the following cycle imem_req=1 with imem_addr=32.
- Sequential fetch: ack returned immediately, instr_ready tied 1 -> pc_inc pulses every 3 cycles; addresses 32, 33, 34 requested in order.
- Branch while waiting: br_valid=1 with br_target=100 during REQ, ack delayed 4 cycles -> UPDATE asserts pc_load with pc_data=100; the next imem_addr is 100; pc_inc stays 0 in that UPDATE.
- Backpressure then halt: instr_ready=0 for 5 cycles -> instr_valid held and instr stable. Then ready=1 with halt=1 -> one pc_inc, state HALTED, busy=0. Then start=1 with halt=0 -> resumes at the incremented PC.
- Timeout: MAX_WAIT=15, imem_ack never asserted -> after 15 REQ cycles err=1 and imem_req=0; err stays 1 until rst; after rst, err=0.
- Reset mid-operation: rst=1 during ISSUE -> next cycle IDLE, instr_valid=0, instr=0, pending branch cleared. With PC_FETCH_PERF_EN defined, both perf counters read 0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch sequencer: boots the PC, fetches one instruction at a
// time, hands it to decode, then increments or branches. Optional counters: PC_FETCH_PERF_EN.
module pc_fetch_ctrl #(
  parameter int          N         = 32,
  parameter int unsigned RESET_VEC = 32,
  parameter int          MAX_WAIT  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  input  logic [N-1:0]  pc_in,
  output logic [N-1:0]  pc_data,
  output logic          pc_load,
  output logic          pc_inc,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [N-1:0]  imem_rdata,
  output logic [N-1:0]  instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          br_valid,
  input  logic [N-1:0]  br_target,
  output logic          busy,
  output logic          err,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_BOOT, S_REQ, S_ISSUE, S_UPDATE, S_HALTED, S_ERROR
  } state_t;

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          pend_valid;
  logic [N-1:0]  pend_target;

  // A branch presented in UPDATE itself beats any earlier captured one.
  logic          take_branch;
  logic [N-1:0]  branch_pc;
  assign take_branch = br_valid || pend_valid;
  assign branch_pc   = br_valid ? br_target : pend_target;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr       <= '0;
      wait_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      if (br_valid && (state inside {S_BOOT, S_REQ, S_ISSUE})) begin
        pend_valid  <= 1'b1;
        pend_target <= br_target;
      end
      case (state)
        S_IDLE:   if (start) state <= S_BOOT;
        S_BOOT:   state <= S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            wait_cnt <= '0;
            state    <= S_ISSUE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_ISSUE:  if (instr_ready) state <= S_UPDATE;
        S_UPDATE: begin
          if (take_branch) pend_valid <= 1'b0;
          state <= halt ? S_HALTED : S_REQ;
        end
        S_HALTED: if (start && !halt) state <= S_REQ;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    pc_data = '0;
    case (state)
      S_BOOT: begin
        pc_load = 1'b1;
        pc_data = N'(RESET_VEC);
      end
      S_UPDATE: begin
        if (take_branch) begin
          pc_load = 1'b1;
          pc_data = branch_pc;
        end else begin
          pc_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = imem_req ? pc_in : '0;
  assign instr_valid = (state == S_ISSUE);
  assign err         = (state == S_ERROR);
  assign busy        = !(state inside {S_IDLE, S_HALTED, S_ERROR});

`ifdef PC_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == S_ISSUE && instr_ready) fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == S_REQ && !imem_ack) || (state == S_ISSUE && !instr_ready))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus a randomized stream checked
// against a transaction-level PC/branch model.
module tb_pc_fetch_ctrl;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst, start, halt;
  logic [N-1:0]  pc_in, pc_data, imem_addr, imem_rdata, instr, br_target;
  logic          pc_load, pc_inc, imem_req, imem_ack, instr_valid, instr_ready;
  logic          br_valid, busy, err;
  logic [31:0]   perf_fetch_cnt, perf_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.N(N), .RESET_VEC(32), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .pc_in(pc_in),
    .pc_data(pc_data), .pc_load(pc_load), .pc_inc(pc_inc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_valid(br_valid), .br_target(br_target),
    .busy(busy), .err(err), .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  // Harness PC counter and instruction memory.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    if (rst)          pc_in <= '0;
    else if (pc_load) pc_in <= pc_data;
    else if (pc_inc)  pc_in <= pc_in + 32'd1;
  end
  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc, pend_t, hold;
    logic        pend_v;
    int unsigned m_fetch, m_stall, snap_f, snap_s, d, r;

    rst = 1; start = 0; halt = 0; imem_ack = 0; instr_ready = 0;
    br_valid = 0; br_target = '0;

    // Boot
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_instr", instr, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_load", pc_load, 0);
    rst = 0; start = 1;
    cyc();
    start = 0;
    chk("boot_load", pc_load, 1);
    chk("boot_data", pc_data, 32);
    chk("boot_inc", pc_inc, 0);
    cyc();
    chk("boot_req", imem_req, 1);
    chk("boot_addr", imem_addr, 32);

    // Sequential fetch, immediate ack, ready tied high
    imem_ack = 1; instr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imem_addr, 32 + i);
      cyc();
      chk("seq_valid", instr_valid, 1);
      chk("seq_instr", instr, mem(32 + i));
      cyc();
      chk("seq_inc", pc_inc, 1);
      chk("seq_noload", pc_load, 0);
      cyc();
    end

    // Branch captured while waiting for a delayed ack
    imem_ack = 0; br_valid = 1; br_target = 100;
    cyc();
    br_valid = 0;
    repeat (3) cyc();
    chk("br_still_req", imem_req, 1);
    imem_ack = 1;
    cyc();
    chk("br_instr", instr, mem(35));
    cyc();
    chk("br_load", pc_load, 1);
    chk("br_data", pc_data, 100);
    chk("br_noinc", pc_inc, 0);
    cyc();
    chk("br_addr", imem_addr, 100);

    // Backpressure, then halt and resume
    instr_ready = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", instr_valid, 1);
      chk("bp_instr", instr, mem(100));
      cyc();
    end
    instr_ready = 1; halt = 1;
    cyc();
    chk("halt_inc", pc_inc, 1);
    chk("halt_noload", pc_load, 0);
    cyc();
    chk("halt_busy", busy, 0);
    chk("halt_req", imem_req, 0);
    halt = 0; start = 1;
    cyc();
    start = 0;
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 101);

    // Fetch timeout
    imem_ack = 0;
    for (int i = 0; i < 15; i++) begin
      chk("to_req", imem_req, 1);
      chk("to_err_low", err, 0);
      cyc();
    end
    chk("to_err", err, 1);
    chk("to_req_low", imem_req, 0);
    chk("to_busy", busy, 0);
    start = 1; imem_ack = 1;
    repeat (3) cyc();
    start = 0;
    chk("to_sticky", err, 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("to_cleared", err, 0);

    // Reset during ISSUE with a pending branch
    start = 1;
    cyc();
    start = 0;
    cyc();
    imem_ack = 1; instr_ready = 0; br_valid = 1; br_target = 200;
    cyc();
    br_valid = 0;
    chk("mid_valid", instr_valid, 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_valid_clr", instr_valid, 0);
    chk("mid_instr_clr", instr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_perf_f", perf_fetch_cnt, 0);
    chk("mid_perf_s", perf_stall_cnt, 0);
    start = 1;
    cyc();
    start = 0;
    cyc();
    chk("mid_addr", imem_addr, 32);
    instr_ready = 1;
    cyc();
    cyc();
    chk("mid_nopend_inc", pc_inc, 1);
    chk("mid_nopend_load", pc_load, 0);
    cyc();

    // Randomized stream against a transaction-level model
    exp_pc = 33; pend_v = 0; pend_t = '0;
    m_fetch = 0; m_stall = 0;
    snap_f = perf_fetch_cnt; snap_s = perf_stall_cnt;
    for (int i = 0; i < 30; i++) begin
      chk("rnd_req", imem_req, 1);
      chk("rnd_addr", imem_addr, exp_pc);
      d = $urandom_range(0, 3);
      for (int k = 0; k <= int'(d); k++) begin
        imem_ack  = (k == int'(d));
        br_valid  = ($urandom_range(0, 3) == 0);
        br_target = $urandom_range(0, 65535);
        if (br_valid) begin pend_v = 1; pend_t = br_target; end
        if (!imem_ack) m_stall++;
        cyc();
      end
      br_valid = 0; imem_ack = 0;
      chk("rnd_valid", instr_valid, 1);
      chk("rnd_instr", instr, mem(exp_pc));
      hold = mem(exp_pc);
      r = $urandom_range(0, 3);
      for (int k = 0; k <= int'(r); k++) begin
        instr_ready = (k == int'(r));
        br_valid    = ($urandom_range(0, 3) == 0);
        br_target   = $urandom_range(0, 65535);
        if (br_valid) begin pend_v = 1; pend_t = br_target; end
        if (instr_ready) m_fetch++; else m_stall++;
        if (k > 0) chk("rnd_stable", instr, hold);
        cyc();
      end
      instr_ready = 0;
      br_valid    = ($urandom_range(0, 3) == 0);
      br_target   = $urandom_range(0, 65535);
      #1;
      if (br_valid || pend_v) begin
        if (br_valid) exp_pc = br_target; else exp_pc = pend_t;
        chk("rnd_load", pc_load, 1);
        chk("rnd_data", pc_data, exp_pc);
        chk("rnd_noinc", pc_inc, 0);
      end else begin
        exp_pc = exp_pc + 32'd1;
        chk("rnd_inc", pc_inc, 1);
        chk("rnd_noload", pc_load, 0);
      end
      pend_v = 0;
      cyc();
      br_valid = 0;
    end
    chk("rnd_busy", busy, 1);
`ifdef PC_FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt - snap_f, m_fetch);
    chk("perf_stall", perf_stall_cnt - snap_s, m_stall);
`else
    chk("perf_fetch_off", perf_fetch_cnt, 0);
    chk("perf_stall_off", perf_stall_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
